// File: rtl/cache_miss_sequencer.sv
// Cache miss sequencer: latches a CPU read address, checks the cache tag hit,
// fetches a 4-word block from RAM on a miss, fills the cache for one cycle,
// and returns the requested word with a single-cycle done pulse. Keeps
// saturating hit/miss statistics.
module cache_miss_sequencer #(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_WIDTH  = 15,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic [ADDR_WIDTH-1:0]    address,
    output logic [ADDR_WIDTH-1:0]    cache_addr,
    input  logic                     hit,
    input  logic [WORD_LENGTH-1:0]   cache_data,
    output logic                     ram_read,
    input  logic                     ram_ready,
    input  logic [4*WORD_LENGTH-1:0] ram_block,
    output logic                     cache_write,
    output logic [4*WORD_LENGTH-1:0] fill_block,
    output logic [WORD_LENGTH-1:0]   data_out,
    output logic                     done,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     hit_count,
    output logic [CNT_WIDTH-1:0]     miss_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_WAIT = 3'd2,
        FILL      = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Saturating increment: the statistics stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (value == CNT_MAX) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_ONE;
        end
    endfunction

    // Pick the word of a RAM block addressed by the low two address bits.
    function automatic logic [WORD_LENGTH-1:0] select_word(
        input logic [4*WORD_LENGTH-1:0] blk,
        input logic [1:0]               sel
    );
        case (sel)
            2'b00:   select_word = blk[1*WORD_LENGTH-1 : 0];
            2'b01:   select_word = blk[2*WORD_LENGTH-1 : 1*WORD_LENGTH];
            2'b10:   select_word = blk[3*WORD_LENGTH-1 : 2*WORD_LENGTH];
            2'b11:   select_word = blk[4*WORD_LENGTH-1 : 3*WORD_LENGTH];
            default: select_word = {WORD_LENGTH{1'b0}};
        endcase
    endfunction

    state_t                   state_r;
    state_t                   next_state_s;
    logic [ADDR_WIDTH-1:0]    cache_addr_r;
    logic [ADDR_WIDTH-1:0]    cache_addr_s;
    logic [WORD_LENGTH-1:0]   data_out_r;
    logic [WORD_LENGTH-1:0]   data_out_s;
    logic [4*WORD_LENGTH-1:0] fill_block_r;
    logic [4*WORD_LENGTH-1:0] fill_block_s;
    logic [CNT_WIDTH-1:0]     hit_count_r;
    logic [CNT_WIDTH-1:0]     hit_count_s;
    logic [CNT_WIDTH-1:0]     miss_count_r;
    logic [CNT_WIDTH-1:0]     miss_count_s;

    // Next-state and datapath-update logic; hit, cache_data and ram_ready are
    // only looked at in the states that own them, so X elsewhere never loads.
    always_comb begin
        next_state_s = state_r;
        cache_addr_s = cache_addr_r;
        data_out_s   = data_out_r;
        fill_block_s = fill_block_r;
        hit_count_s  = hit_count_r;
        miss_count_s = miss_count_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    cache_addr_s = address;
                    next_state_s = LOOKUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    data_out_s   = cache_data;
                    hit_count_s  = sat_inc(hit_count_r);
                    next_state_s = RESPOND;
                end else begin
                    miss_count_s = sat_inc(miss_count_r);
                    next_state_s = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (ram_ready) begin
                    fill_block_s = ram_block;
                    data_out_s   = select_word(ram_block, cache_addr_r[1:0]);
                    next_state_s = FILL;
                end else begin
                    next_state_s = MISS_WAIT;
                end
            end
            FILL:    next_state_s = RESPOND;
            RESPOND: next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cache_addr_r <= {ADDR_WIDTH{1'b0}};
            data_out_r   <= {WORD_LENGTH{1'b0}};
            fill_block_r <= {(4*WORD_LENGTH){1'b0}};
            hit_count_r  <= {CNT_WIDTH{1'b0}};
            miss_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r      <= next_state_s;
            cache_addr_r <= cache_addr_s;
            data_out_r   <= data_out_s;
            fill_block_r <= fill_block_s;
            hit_count_r  <= hit_count_s;
            miss_count_r <= miss_count_s;
        end
    end

    // Control strobes are pure decodes of the state register, so they fall
    // together with an asynchronous reset.
    assign ram_read    = (state_r == MISS_WAIT);
    assign cache_write = (state_r == FILL);
    assign done        = (state_r == RESPOND);
    assign busy        = (state_r != IDLE);

    assign cache_addr  = cache_addr_r;
    assign data_out    = data_out_r;
    assign fill_block  = fill_block_r;
    assign hit_count   = hit_count_r;
    assign miss_count  = miss_count_r;

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Directed bench for cache_miss_sequencer: reset/abort, hit, stalled miss,
// word-select sweep, back-to-back requests and counter saturation.
module tb_cache_miss_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         req_sat;
    logic [14:0]  address;
    logic         hit;
    logic [31:0]  cache_data;
    logic         ram_ready;
    logic [127:0] ram_block;

    logic [14:0]  cache_addr;
    logic         ram_read;
    logic         cache_write;
    logic [127:0] fill_block;
    logic [31:0]  data_out;
    logic         done;
    logic         busy;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    logic [14:0]  sat_cache_addr;
    logic         sat_ram_read;
    logic         sat_cache_write;
    logic [127:0] sat_fill_block;
    logic [31:0]  sat_data_out;
    logic         sat_done;
    logic         sat_busy;
    logic [1:0]   sat_hit_count;
    logic [1:0]   sat_miss_count;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    cache_miss_sequencer dut (
        .clk(clk), .rst(rst), .req(req), .address(address),
        .cache_addr(cache_addr), .hit(hit), .cache_data(cache_data),
        .ram_read(ram_read), .ram_ready(ram_ready), .ram_block(ram_block),
        .cache_write(cache_write), .fill_block(fill_block), .data_out(data_out),
        .done(done), .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
    );

    // Narrow-counter instance so saturation is reachable in a few requests.
    cache_miss_sequencer #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .req(req_sat), .address(address),
        .cache_addr(sat_cache_addr), .hit(1'b1), .cache_data(cache_data),
        .ram_read(sat_ram_read), .ram_ready(ram_ready), .ram_block(ram_block),
        .cache_write(sat_cache_write), .fill_block(sat_fill_block), .data_out(sat_data_out),
        .done(sat_done), .busy(sat_busy), .hit_count(sat_hit_count), .miss_count(sat_miss_count)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request from IDLE; ram_ready rises after 'stall' MISS_WAIT cycles.
    task automatic run_txn(
        input  logic [14:0]  a,
        input  logic         h,
        input  logic [31:0]  cd,
        input  int           stall,
        input  logic [127:0] blk,
        output int           done_cyc,
        output int           rr_cyc,
        output int           cw_cyc,
        output logic [127:0] fb_seen,
        output logic [31:0]  data_seen,
        output logic [14:0]  addr_seen,
        output logic         done_after
    );
        int mw;
        mw = 0; done_cyc = -1; rr_cyc = 0; cw_cyc = 0;
        fb_seen = 128'h0; data_seen = 32'h0; addr_seen = 15'h0; done_after = 1'b1;
        @(negedge clk);
        address = a; req = 1'b1; hit = h; cache_data = cd; ram_ready = 1'b0; ram_block = blk;
        @(posedge clk);
        #1;
        req = 1'b0;
        address = ~a;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (ram_read) begin
                rr_cyc++;
                mw++;
                ram_ready = (mw > stall);
            end
            if (cache_write) begin
                cw_cyc++;
                fb_seen = fill_block;
            end
            if (cyc >= 2) begin
                hit = 1'bx;
                cache_data = 32'hxxxxxxxx;
            end
            if (done) begin
                done_cyc  = cyc;
                data_seen = data_out;
                addr_seen = cache_addr;
                break;
            end
        end
        @(negedge clk);
        done_after = done;
        ram_ready = 1'b0; hit = 1'b0; cache_data = 32'h0;
    endtask

    task automatic sat_hit();
        @(negedge clk);
        req_sat = 1'b1;
        @(posedge clk);
        #1;
        req_sat = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           dc, rr, cw, nd, dbl, bad_addr, k, cnt_cw, cnt_done, cnt_busy;
        logic [127:0] fb, blk, blk2;
        logic [31:0]  dat;
        logic [14:0]  ad;
        logic         da, prev_done;
        logic [14:0]  sw_addr [3];
        logic [31:0]  sw_exp  [3];
        logic [14:0]  qa [3];
        logic         qh [3];
        logic [31:0]  qd [3];
        logic [31:0]  got [3];

        rst = 1'b1; req = 1'b0; req_sat = 1'b0; hit = 1'b0; address = 15'h0;
        cache_data = 32'h0; ram_ready = 1'b0; ram_block = 128'h0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {124'h0, ram_read, cache_write, done, busy}, 128'h0);
        check("reset_cnt", {96'h0, hit_count, miss_count}, 128'h0);
        rst = 1'b0;

        // Drive into MISS_WAIT, then reset mid-cycle.
        @(negedge clk);
        address = 15'h0042; hit = 1'b0; req = 1'b1; ram_ready = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort_ram_read", {127'h0, ram_read}, 128'h1);
        check("pre_abort_miss_count", {112'h0, miss_count}, 128'h1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_ctrl_immediate", {124'h0, ram_read, cache_write, done, busy}, 128'h0);
        check("abort_regs", {49'h0, cache_addr, data_out, hit_count, miss_count}, 128'h0);
        check("abort_fill_block", fill_block, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        ram_ready = 1'b1;
        cnt_cw = 0; cnt_done = 0; cnt_busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cache_write) cnt_cw++;
            if (done) cnt_done++;
            if (busy) cnt_busy++;
        end
        ram_ready = 1'b0;
        check("abort_no_write_done_busy", {96'h0, cnt_cw, cnt_done, cnt_busy}, 128'h0);
        check("abort_counters", {96'h0, hit_count, miss_count}, 128'h0);

        // Hit
        run_txn(15'h0123, 1'b1, 32'hDEADBEEF, 0, 128'h0, dc, rr, cw, fb, dat, ad, da);
        check("hit_latency", 128'(dc), 128'd2);
        check("hit_data", {96'h0, dat}, {96'h0, 32'hDEADBEEF});
        check("hit_addr", {113'h0, ad}, {113'h0, 15'h0123});
        check("hit_no_ram_read", 128'(rr), 128'd0);
        check("hit_no_cache_write", 128'(cw), 128'd0);
        check("hit_done_single", {127'h0, da}, 128'h0);
        check("hit_counts", {96'h0, hit_count, miss_count}, {96'h0, 16'd1, 16'd0});

        // Miss with 3 stall cycles
        blk = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        run_txn(15'h0042, 1'b0, 32'hBAD0BAD0, 3, blk, dc, rr, cw, fb, dat, ad, da);
        check("miss_ram_read_cycles", 128'(rr), 128'd4);
        check("miss_cache_write_cycles", 128'(cw), 128'd1);
        check("miss_fill_block", fb, blk);
        check("miss_data_word2", {96'h0, dat}, {96'h0, 32'h33333333});
        check("miss_latency", 128'(dc), 128'd7);
        check("miss_done_single", {127'h0, da}, 128'h0);
        check("miss_counts", {96'h0, hit_count, miss_count}, {96'h0, 16'd1, 16'd1});

        // Word select sweep
        sw_addr = '{15'h0040, 15'h0041, 15'h0043};
        sw_exp  = '{32'h11111111, 32'h22222222, 32'h44444444};
        for (int i = 0; i < 3; i++) begin
            run_txn(sw_addr[i], 1'b0, 32'h0, 0, blk, dc, rr, cw, fb, dat, ad, da);
            check($sformatf("sweep_data_%0d", i), {96'h0, dat}, {96'h0, sw_exp[i]});
            check($sformatf("sweep_latency_%0d", i), 128'(dc), 128'd4);
        end
        check("sweep_miss_count", {112'h0, miss_count}, {112'h0, 16'd4});

        // Back-to-back hit, miss, hit with req held and address toggling
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        blk2 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        qa = '{15'h0100, 15'h0201, 15'h0303};
        qh = '{1'b1, 1'b0, 1'b1};
        qd = '{32'hA5A5A5A5, 32'h0BADF00D, 32'h5A5A5A5A};
        got = '{32'h0, 32'h0, 32'h0};
        ram_block = blk2; ram_ready = 1'b1;
        k = 0; nd = 0; dbl = 0; bad_addr = 0; prev_done = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (prev_done) dbl++;
                if (nd < 3) got[nd] = data_out;
                nd++;
            end
            prev_done = done;
            if (!busy) begin
                if (k < 3) begin
                    address = qa[k]; hit = qh[k]; cache_data = qd[k]; req = 1'b1;
                    k++;
                end else begin
                    req = 1'b0;
                    break;
                end
            end else begin
                if (cache_addr !== qa[k-1]) bad_addr++;
                address = 15'($urandom);
            end
        end
        req = 1'b0; ram_ready = 1'b0;
        check("b2b_done_count", 128'(nd), 128'd3);
        check("b2b_done_single", 128'(dbl), 128'd0);
        check("b2b_addr_stable", 128'(bad_addr), 128'd0);
        check("b2b_data0", {96'h0, got[0]}, {96'h0, 32'hA5A5A5A5});
        check("b2b_data1", {96'h0, got[1]}, {96'h0, 32'hBBBB0001});
        check("b2b_data2", {96'h0, got[2]}, {96'h0, 32'h5A5A5A5A});
        check("b2b_counts", {96'h0, hit_count, miss_count}, {96'h0, 16'd2, 16'd1});

        // Saturation on the 2-bit counter instance
        sat_hit();
        sat_hit();
        check("sat_preload", {126'h0, sat_hit_count}, {126'h0, 2'b10});
        sat_hit();
        check("sat_reach_max", {126'h0, sat_hit_count}, {126'h0, 2'b11});
        sat_hit();
        sat_hit();
        check("sat_hold_max", {126'h0, sat_hit_count}, {126'h0, 2'b11});
        check("sat_no_miss", {126'h0, sat_miss_count}, 128'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
